// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths and MEM-stage FSM encodings
package mem_access_stage_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// mem_timeout_ctr: bus-watchdog cycle counter with terminal-count flag
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store sequencer, output port and bus watchdog
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int                TIMEOUT_CYC = 16,
  parameter logic [DATA_W-1:0] ERR_DATA    = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              io_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data_B,
  output logic              stall,
  output logic [DATA_W-1:0] out_port,
  output logic              bus_err
);
  mem_state_t state, state_nxt;
  logic start, busy, tc, done;
  assign busy  = state == MEM_BUSY;
  assign start = in_valid & (mem_read | mem_write) & (state == MEM_IDLE);
  assign done  = busy & (mem_ack | tc);
  assign stall = !rst & (start | busy);
  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .en (busy),
    .tc (tc)
  );
  always_comb begin
    state_nxt = MEM_IDLE;
    state_nxt = (state == MEM_IDLE) ? (start ? MEM_BUSY : MEM_IDLE) :
                busy                ? (done ? MEM_RESP : MEM_BUSY) : MEM_IDLE;
  end
  // ack has priority over timeout when both land in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= MEM_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_B    <= '0;
      out_port  <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_write;
        mem_addr  <= addr;
        mem_wdata <= wdata;
      end else if (done) begin
        mem_req <= 1'b0;
        if (!mem_we) data_B <= mem_ack ? mem_rdata : ERR_DATA;
        if (!mem_ack) bus_err <= 1'b1;
      end
      if (in_valid && io_write && !stall) out_port <= wdata;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized transaction-level check of the MEM stage
module tb_mem_access_stage;
  localparam int T = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, mem_read = 0, mem_write = 0, io_write = 0, mem_ack = 0;
  logic [7:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic mem_req, mem_we, stall, bus_err;
  logic [7:0] mem_addr, mem_wdata, data_B, out_port;
  int n_checks = 0, n_fail = 0;
  logic [7:0] m_data_b = 0, m_out = 0;
  logic m_err = 0;
  int r_stall, r_req, e_req, e_stall;
  logic r_done, r_unstable, r_we;
  logic [7:0] r_addr, r_wdata, r_data;

  mem_access_stage #(.TIMEOUT_CYC(T), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
    .mem_write(mem_write), .io_write(io_write), .addr(addr), .wdata(wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .data_B(data_B), .stall(stall),
    .out_port(out_port), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Transaction-level expectation: ack on BUSY cycle ack_at (1..T) or timeout after T
  task automatic model(input logic rd, wr, io, input logic [7:0] wd, rdat, input int ack_at);
    logic mem, to;
    mem = rd | wr;
    to = mem && !(ack_at >= 1 && ack_at <= T);
    e_req = !mem ? 0 : to ? T : ack_at;
    e_stall = mem ? e_req + 1 : 0;
    if (rd && !wr) m_data_b = to ? 8'hFF : rdat;
    if (to) m_err = 1'b1;
    if (io) m_out = wd;
  endtask

  // Drives one instruction until the pipeline is released, measuring bus behaviour
  task automatic run_op(input logic rd, wr, io, input logic [7:0] a, wd, rdat, input int ack_at);
    in_valid = 1; mem_read = rd; mem_write = wr; io_write = io;
    addr = a; wdata = wd; mem_rdata = rdat; mem_ack = 0;
    r_stall = 0; r_req = 0; r_unstable = 0; r_done = 0;
    for (int c = 0; c < 20 && !r_done; c++) begin
      #1;
      if (mem_req) begin
        if (r_req == 0) begin r_addr = mem_addr; r_we = mem_we; r_wdata = mem_wdata; end
        else if ({mem_addr, mem_we, mem_wdata} !== {r_addr, r_we, r_wdata}) r_unstable = 1;
        r_req++;
      end
      mem_ack = mem_req && (r_req == ack_at);
      #1;
      if (stall) r_stall++;
      else begin r_done = 1; r_data = data_B; end
      @(posedge clk); #1;
      mem_ack = 0;
    end
    in_valid = 0; mem_read = 0; mem_write = 0; io_write = 0;
  endtask

  task automatic test_reset();
    in_valid = 1; mem_read = 1;
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we: got %b%b expected 00", mem_req, mem_we); end
    n_checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_addr_wdata: got %h %h expected 00 00", mem_addr, mem_wdata); end
    n_checks++; if (data_B !== 8'h00 || out_port !== 8'h00 || bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_data_out_err: got %h %h %b expected 00 00 0", data_B, out_port, bus_err); end
    in_valid = 0; mem_read = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    model(1, 0, 0, 8'h00, 8'h5A, 1);
    run_op(1, 0, 0, 8'h20, 8'h00, 8'h5A, 1);
    n_checks++; if (r_req !== 1) begin n_fail++; $display("FAIL load_req_cycles: got %0d expected 1", r_req); end
    n_checks++; if (r_addr !== 8'h20 || r_we !== 1'b0) begin n_fail++; $display("FAIL load_addr_we: got %h %b expected 20 0", r_addr, r_we); end
    n_checks++; if (r_stall !== 2) begin n_fail++; $display("FAIL load_stall_cycles: got %0d expected 2", r_stall); end
    n_checks++; if (r_data !== 8'h5A) begin n_fail++; $display("FAIL load_data_B: got %h expected 5a", r_data); end
  endtask

  task automatic test_store();
    model(0, 1, 0, 8'hC3, 8'h99, 3);
    run_op(0, 1, 0, 8'h40, 8'hC3, 8'h99, 3);
    n_checks++; if (r_req !== 3 || r_unstable !== 1'b0) begin n_fail++; $display("FAIL store_req_stable: got %0d cycles unstable=%b expected 3 stable", r_req, r_unstable); end
    n_checks++; if (r_we !== 1'b1 || r_wdata !== 8'hC3 || r_addr !== 8'h40) begin n_fail++; $display("FAIL store_bus: got we=%b %h %h expected 1 c3 40", r_we, r_wdata, r_addr); end
    n_checks++; if (r_stall !== 4) begin n_fail++; $display("FAIL store_stall_cycles: got %0d expected 4", r_stall); end
    n_checks++; if (data_B !== 8'h5A) begin n_fail++; $display("FAIL store_data_B: got %h expected 5a", data_B); end
  endtask

  task automatic test_rw_both();
    model(1, 1, 0, 8'h11, 8'hE7, 1);
    run_op(1, 1, 0, 8'h08, 8'h11, 8'hE7, 1);
    n_checks++; if (r_we !== 1'b1 || r_wdata !== 8'h11) begin n_fail++; $display("FAIL rw_bus: got we=%b %h expected 1 11", r_we, r_wdata); end
    n_checks++; if (data_B !== m_data_b) begin n_fail++; $display("FAIL rw_data_B: got %h expected %h", data_B, m_data_b); end
  endtask

  task automatic test_timeout();
    model(1, 0, 0, 8'h00, 8'h42, 0);
    run_op(1, 0, 0, 8'h30, 8'h00, 8'h42, 0);
    n_checks++; if (r_req !== T || r_done !== 1'b1) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d done=%b expected %0d released", r_req, r_done, T); end
    n_checks++; if (bus_err !== 1'b1 || data_B !== 8'hFF) begin n_fail++; $display("FAIL timeout_err_data: got %b %h expected 1 ff", bus_err, data_B); end
    model(1, 0, 0, 8'h00, 8'h24, 2);
    run_op(1, 0, 0, 8'h31, 8'h00, 8'h24, 2);
    n_checks++; if (bus_err !== 1'b1 || data_B !== 8'h24) begin n_fail++; $display("FAIL timeout_sticky: got %b %h expected 1 24", bus_err, data_B); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; addr = 8'h55; wdata = 8'h01;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    io_write = 1; wdata = 8'h77;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL out_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    m_out = 8'h77;
    n_checks++; if (out_port !== 8'h77) begin n_fail++; $display("FAIL out_port: got %h expected 77", out_port); end
    in_valid = 0; io_write = 0; mem_ack = 1; mem_rdata = 8'hEE; wdata = 8'h99;
    #2;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bubble_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    mem_ack = 0;
    n_checks++; if (mem_req !== 1'b0 || data_B !== m_data_b || out_port !== 8'h77) begin n_fail++; $display("FAIL spurious_ack: got req=%b %h %h expected 0 %h 77", mem_req, data_B, out_port, m_data_b); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; mem_read = 1; addr = 8'h33; mem_ack = 0;
    @(posedge clk); #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b expected 1", mem_req); end
    #1 rst = 1;
    #1;
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_req_stall: got %b %b expected 0 0", mem_req, stall); end
    n_checks++; if (bus_err !== 1'b0 || out_port !== 8'h00 || data_B !== 8'h00) begin n_fail++; $display("FAIL rst_err_out_data: got %b %h %h expected 0 00 00", bus_err, out_port, data_B); end
    in_valid = 0; mem_read = 0;
    @(negedge clk); rst = 0;
    m_data_b = 0; m_out = 0; m_err = 0;
    @(posedge clk); #1;
    model(1, 0, 0, 8'h00, 8'h3C, 2);
    run_op(1, 0, 0, 8'h34, 8'h00, 8'h3C, 2);
    n_checks++; if (r_req !== 2 || data_B !== 8'h3C || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_after_load: got %0d %h %b expected 2 3c 0", r_req, data_B, bus_err); end
  endtask

  task automatic test_random();
    logic rd, wr, io;
    logic [7:0] a, wd, rdat;
    int ack_at;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom); wr = 1'($urandom); io = 1'($urandom);
      a = 8'($urandom); wd = 8'($urandom); rdat = 8'($urandom);
      ack_at = $urandom_range(0, T + 2);
      model(rd, wr, io, wd, rdat, ack_at);
      run_op(rd, wr, io, a, wd, rdat, ack_at);
      n_checks++; if (r_req !== e_req || r_stall !== e_stall || r_unstable !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timing: got req=%0d stall=%0d unstable=%b expected %0d %0d 0", i, r_req, r_stall, r_unstable, e_req, e_stall); end
      if (rd | wr) begin
        n_checks++; if (r_addr !== a || r_we !== wr || r_wdata !== wd) begin n_fail++; $display("FAIL rand%0d_bus: got %h %b %h expected %h %b %h", i, r_addr, r_we, r_wdata, a, wr, wd); end
      end
      n_checks++; if (data_B !== m_data_b || bus_err !== m_err || out_port !== m_out) begin n_fail++; $display("FAIL rand%0d_state: got %h %b %h expected %h %b %h", i, data_B, bus_err, out_port, m_data_b, m_err, m_out); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_rw_both();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
